// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader and its stream drivers:
// FSM state encoding and boot-stream framing constants.
package imem_boot_loader_pkg;

   typedef enum logic [2:0] {
      CNT_LO,
      CNT_HI,
      DATA,
      CSUM,
      DONE,
      ERR
   } state_t;

   localparam int HDR_BYTES  = 2;
   localparam int CNT_W      = 8 * HDR_BYTES;
   localparam int WORD_BYTES = 4;
   localparam int CSUM_W     = 8;

   function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                  input logic [7:0]        b);
      return acc + CSUM_W'(b);
   endfunction

endpackage

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: parses a counted little-endian word stream, writes it into
// instruction memory one word at a time, verifies a mod-256 checksum and releases the core.
module imem_boot_loader
   import imem_boot_loader_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int CSUM_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              reload,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst,
   output logic              done,
   output logic              error
);

   localparam int CW = CNT_W + 1;
   localparam logic [CW-1:0] MAX_WORDS = CW'(1) << ADDR_W;

   state_t             state;
   logic [7:0]         cnt_lo;
   logic [CNT_W-1:0]   n_words;
   logic [CNT_W-1:0]   word_idx;
   logic [1:0]         byte_idx;
   logic [23:0]        asm_buf;
   logic [CSUM_W-1:0]  csum;
   logic               xfer;
   logic [CNT_W-1:0]   hdr_n;

   assign in_ready = (state != DONE) && (state != ERR);
   assign xfer     = in_valid && in_ready;
   assign hdr_n    = {in_data, cnt_lo};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= CNT_LO;
         core_rst   <= 1'b1;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         done       <= 1'b0;
         error      <= 1'b0;
         cnt_lo     <= '0;
         n_words    <= '0;
         word_idx   <= '0;
         byte_idx   <= '0;
         asm_buf    <= '0;
         csum       <= '0;
      end else begin
         imem_we <= 1'b0;
         case (state)
            CNT_LO: begin
               if (xfer) begin
                  cnt_lo <= in_data;
                  state  <= CNT_HI;
               end
            end
            CNT_HI: begin
               if (xfer) begin
                  n_words <= hdr_n;
                  if (hdr_n == '0) begin
                     state <= CSUM;
                  end else if ({1'b0, hdr_n} > MAX_WORDS) begin
                     state <= ERR;
                     error <= 1'b1;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (xfer) begin
                  csum     <= csum_add(csum, in_data);
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: asm_buf[7:0]   <= in_data;
                     2'd1: asm_buf[15:8]  <= in_data;
                     2'd2: asm_buf[23:16] <= in_data;
                     default: begin
                        // Fourth byte completes the word; the write strobe follows one cycle later.
                        imem_we    <= 1'b1;
                        imem_addr  <= word_idx[ADDR_W-1:0];
                        imem_wdata <= {in_data, asm_buf};
                        word_idx   <= word_idx + CNT_W'(1);
                        if (word_idx == n_words - CNT_W'(1)) state <= CSUM;
                     end
                  endcase
               end
            end
            CSUM: begin
               if (xfer) begin
                  if ((CSUM_EN == 0) || (in_data == csum)) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     core_rst <= 1'b0;
                  end else begin
                     state <= ERR;
                     error <= 1'b1;
                  end
               end
            end
            DONE, ERR: begin
               if (reload) begin
                  state    <= CNT_LO;
                  core_rst <= 1'b1;
                  done     <= 1'b0;
                  error    <= 1'b0;
                  cnt_lo   <= '0;
                  n_words  <= '0;
                  word_idx <= '0;
                  byte_idx <= '0;
                  asm_buf  <= '0;
                  csum     <= '0;
               end
            end
            default: state <= CNT_LO;
         endcase
      end
   end

endmodule

// File: doc/imem_boot_loader.md
IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 Parameter ADDR_W, default 10, instruction-memory word-address width (capacity 2^ADDR_W words).
REQ-002 Parameter CSUM_EN, default 1, 1 = checksum byte checked, 0 = checksum byte consumed but ignored.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 in_data  input  8  boot-stream byte.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  loader can accept a byte; transfer occurs on cycles with in_valid && in_ready.
REQ-008 reload  input  1  one-cycle pulse; restarts loading from DONE or ERR.
REQ-009 imem_we  output  1  instruction-memory write strobe.
REQ-010 imem_addr  output  ADDR_W  word address of the write.
REQ-011 imem_wdata  output  32  instruction word to write.
REQ-012 core_rst  output  1  active-high reset to the single-cycle core; held while loading.
REQ-013 done  output  1  load completed and verified.
REQ-014 error  output  1  load failed (oversize count or checksum mismatch).

Function
REQ-015 Stream format: count low byte, count high byte (16-bit word count N, little-endian), 4*N payload bytes, one checksum byte.
REQ-016 FSM states: CNT_LO, CNT_HI, DATA, CSUM, DONE, ERR.
REQ-017 in_ready = 1 in CNT_LO, CNT_HI, DATA, CSUM; 0 in DONE, ERR.
REQ-018 CNT_LO -> CNT_HI on byte transfer; CNT_HI -> DATA on transfer if 0 < N <= 2^ADDR_W, -> CSUM if N = 0, -> ERR if N > 2^ADDR_W.
REQ-019 Payload bytes assemble little-endian: 1st byte = wdata[7:0] ... 4th byte = wdata[31:24].
REQ-020 imem_we high exactly one cycle, the cycle after the 4th byte of a word transfers; imem_addr = word index (0, 1, ... N-1), imem_wdata = assembled word, both stable while imem_we high.
REQ-021 imem_we low in all other cycles; imem_addr/imem_wdata hold last values.
REQ-022 DATA -> CSUM on transfer of byte 4*N.
REQ-023 Checksum = 8-bit modulo-256 sum of all payload bytes (header excluded).
REQ-024 CSUM -> DONE on transfer if CSUM_EN = 0 or byte equals checksum; else -> ERR.
REQ-025 done = 1 only in DONE; error = 1 only in ERR; both registered.
REQ-026 core_rst = 1 in all states except DONE; deasserts in the first cycle DONE is entered.
REQ-027 in_valid low cycles stall the FSM with no state, counter, or checksum change.
REQ-028 reload in DONE or ERR -> CNT_LO next cycle, core_rst = 1, done = error = 0, checksum and counters cleared; reload ignored in other states.
REQ-029 Bytes presented while in_ready = 0 are not consumed.

Reset
REQ-030 rst low at a rising edge, including mid-load, forces: state CNT_LO, core_rst = 1, in_ready = 1 (from next cycle), imem_we = 0, imem_addr = 0, imem_wdata = 0, done = 0, error = 0, byte/word counters and checksum = 0.
REQ-031 Reset has priority over reload and over any in-flight byte transfer.

Structure
REQ-032 State encoding and stream-format constants (header length, checksum width) reside in a shared package used by the loader and the boot-stream bench driver.
REQ-033 No sub-module; FSM, byte assembler, counters, and checksum accumulator all in imem_boot_loader.

Verification
REQ-034 Stream 05 00, 93 00 50 00, 13 01 70 00, b3 81 20 00, 23 20 30 00, 03 22 00 00, 53 -> five single-cycle writes addr 0..4 with 00500093, 00700113, 002081b3, 00302023, 00002203; done = 1, core_rst = 0; core then yields x1 = 5, x2 = 7, x3 = 12, x4 = 12.
REQ-035 Same stream with checksum 54 -> same five writes, error = 1, done = 0, core_rst stays 1, in_ready = 0.
REQ-036 Stream 00 00 00 -> no imem_we pulses, done = 1 after checksum byte.
REQ-037 Stream 01 04 (N = 0x0401, ADDR_W = 10) -> error = 1 the cycle after the high byte, no writes, in_ready = 0.
REQ-038 REQ-034 stream with random in_valid gaps, rst low after the 7th payload byte, then full stream resent -> all outputs at reset values after the reset edge, then five correct writes and done = 1.
REQ-039 reload pulse after done, then REQ-034 stream -> core_rst = 1 the cycle after reload, identical writes, done = 1 again.
